// File: rtl/ps2_host_tx_wishbone.sv
// ps2_host_tx_wishbone: Wishbone slave that sends one host-to-device PS/2 command byte over open-drain k_clk/k_data.
// Registers at ADR_I[3:2]: 0 TXDATA, 1 STATUS {ovr,timeout,nack,done,busy} (W1C [4:1]), 2 CTRL irq_en, 3 reserved.
// Ports: CLK_I/RST_I clock and async active-high reset; STB_I/WE_I/ADR_I/DAT_I/DAT_O/ACK_O Wishbone slave;
//   k_clk_i/k_data_i pad inputs; k_clk_oe/k_data_oe pull-low enables; o_tx_busy transmit in progress;
//   o_interrupt level irq. Macro PS2_TX_IRQ_EN adds the CTRL register and the interrupt, otherwise o_interrupt is 0.
module ps2_host_tx_wishbone #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILTER_LEN = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     STB_I,
  input  logic                     WE_I,
  input  logic [ADDRESS_WIDTH-1:0] ADR_I,
  input  logic [DATA_WIDTH-1:0]    DAT_I,
  output logic [DATA_WIDTH-1:0]    DAT_O,
  output logic                     ACK_O,
  input  logic                     k_clk_i,
  input  logic                     k_data_i,
  output logic                     k_clk_oe,
  output logic                     k_data_oe,
  output logic                     o_tx_busy,
  output logic                     o_interrupt
);
  localparam int CMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAITREL} state_t;
  state_t state, state_nx;
  logic [1:0] clk_sync, dat_sync;
  logic [FW-1:0] clk_run, dat_run;
  logic clk_f, dat_f, clk_f_q, fall;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [8:0] shift;
  logic [7:0] txdata;
  logic data_oe_q, done, nack, tmo_f, ovr;
  logic acc, wr_tx, wr_st, start, last_inh, tmo, set_done, set_nack, set_to, ctrl_rd;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused;
  assign unused = ^{ADR_I[ADDRESS_WIDTH-1:4], ADR_I[1:0], DAT_I[DATA_WIDTH-1:8]};
  assign acc = STB_I & ~ACK_O;
  assign wr_tx = acc & WE_I & (ADR_I[3:2] == 2'd0);
  assign wr_st = acc & WE_I & (ADR_I[3:2] == 2'd1);
  assign start = wr_tx & (state == IDLE);
  assign o_tx_busy = state != IDLE;
  assign fall = clk_f_q & ~clk_f;
  assign last_inh = state == INHIBIT && cnt == CW'(INHIBIT_CYC - 1);
  assign tmo = o_tx_busy && state != INHIBIT && cnt == CW'(TIMEOUT_CYC);
  // Pad inputs: 2-FF synchroniser, then a run filter that only flips after FILTER_LEN agreeing samples
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f <= 1'b1;
      dat_f <= 1'b1;
      clk_f_q <= 1'b1;
      clk_run <= '0;
      dat_run <= '0;
    end else begin
      clk_sync <= {clk_sync[0], k_clk_i};
      dat_sync <= {dat_sync[0], k_data_i};
      clk_f_q <= clk_f;
      clk_run <= clk_sync[1] == clk_f || clk_run == FW'(FILTER_LEN - 1) ? '0 : clk_run + 1'b1;
      dat_run <= dat_sync[1] == dat_f || dat_run == FW'(FILTER_LEN - 1) ? '0 : dat_run + 1'b1;
      clk_f <= clk_sync[1] != clk_f && clk_run == FW'(FILTER_LEN - 1) ? clk_sync[1] : clk_f;
      dat_f <= dat_sync[1] != dat_f && dat_run == FW'(FILTER_LEN - 1) ? dat_sync[1] : dat_f;
    end
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    set_done = 1'b0;
    set_nack = 1'b0;
    set_to = 1'b0;
    k_clk_oe = 1'b0;
    k_data_oe = 1'b0;
    case (state)
      IDLE: state_nx = start ? INHIBIT : IDLE;
      INHIBIT: begin
        k_clk_oe = 1'b1;
        k_data_oe = last_inh;
        state_nx = last_inh ? REQ : INHIBIT;
      end
      REQ: begin
        k_data_oe = 1'b1;
        state_nx = fall ? DATA : REQ;
      end
      DATA: begin
        k_data_oe = data_oe_q;
        state_nx = fall && bit_cnt == 4'd8 ? PARITY : DATA;
      end
      PARITY: begin
        k_data_oe = data_oe_q;
        state_nx = fall ? STOP : PARITY;
      end
      STOP: begin
        set_nack = fall & dat_f;
        state_nx = fall ? WAITREL : STOP;
      end
      WAITREL: begin
        set_done = clk_f & dat_f;
        state_nx = clk_f && dat_f ? IDLE : WAITREL;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo) begin
      state_nx = IDLE;
      set_to = 1'b1;
      set_done = 1'b1;
      k_clk_oe = 1'b0;
      k_data_oe = 1'b0;
    end
  end
  // cnt times the inhibit phase, then measures the gap between device clock falling edges.
  // The host's own clock pull-down during INHIBIT produces a filtered fall, which must not restart the count.
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      txdata <= '0;
      data_oe_q <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      bit_cnt <= '0;
      shift <= {~^DAT_I[7:0], DAT_I[7:0]};
      txdata <= DAT_I[7:0];
      data_oe_q <= 1'b0;
    end else begin
      cnt <= state == IDLE || last_inh || (fall && state != INHIBIT) ? '0 : cnt + 1'b1;
      if (fall && (state == REQ || state == DATA)) begin
        data_oe_q <= ~shift[0];
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) data_oe_q <= 1'b0;
    end
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      done <= 1'b0;
      nack <= 1'b0;
      tmo_f <= 1'b0;
      ovr <= 1'b0;
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      done <= set_done | (done & ~(wr_st & DAT_I[1]) & ~start);
      nack <= set_nack | (nack & ~(wr_st & DAT_I[2]) & ~start);
      tmo_f <= set_to | (tmo_f & ~(wr_st & DAT_I[3]) & ~start);
      ovr <= (wr_tx & o_tx_busy) | (ovr & ~(wr_st & DAT_I[4]));
      ACK_O <= acc;
      DAT_O <= acc && !WE_I ? rdata : '0;
    end
  assign rdata = ADR_I[3:2] == 2'd0 ? DATA_WIDTH'(txdata) :
                 ADR_I[3:2] == 2'd1 ? DATA_WIDTH'({ovr, tmo_f, nack, done, o_tx_busy}) :
                 ADR_I[3:2] == 2'd2 ? DATA_WIDTH'(ctrl_rd) : '0;
`ifdef PS2_TX_IRQ_EN
  logic irq_en;
  assign ctrl_rd = irq_en;
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      irq_en <= 1'b0;
      o_interrupt <= 1'b0;
    end else begin
      irq_en <= acc && WE_I && ADR_I[3:2] == 2'd2 ? DAT_I[0] : irq_en;
      o_interrupt <= irq_en & (done | ovr);
    end
`else
  assign ctrl_rd = 1'b0;
  assign o_interrupt = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_host_tx_wishbone.sv
// tb_ps2_host_tx_wishbone: scoreboard bench driving Wishbone transfers and a PS/2 device model on the open-drain lines.
module tb_ps2_host_tx_wishbone;
  logic CLK_I = 1'b0, RST_I = 1'b1, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0, DAT_O;
  logic ACK_O, k_clk_i, k_data_i, k_clk_oe, k_data_oe, o_tx_busy, o_interrupt;
  logic dev_clk = 1'b1, dev_data = 1'b1, rd_req = 1'b0;
  logic [10:0] dev_bits;
  event frame_ev;
  int total = 0, bad = 0;
  int inh_run = 0, inh_dat = 0, inh_len = 0, inh_dlen = 0;
  typedef struct {string nm; logic [31:0] v;} rd_exp_t;
  typedef struct {string nm; logic [10:0] v;} fr_exp_t;
  rd_exp_t rd_q[$];
  fr_exp_t fr_q[$];
  assign k_clk_i = dev_clk & ~k_clk_oe;
  assign k_data_i = dev_data & ~k_data_oe;
  ps2_host_tx_wishbone #(.INHIBIT_CYC(20), .TIMEOUT_CYC(400), .FILTER_LEN(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O), .k_clk_i(k_clk_i), .k_data_i(k_data_i), .k_clk_oe(k_clk_oe),
    .k_data_oe(k_data_oe), .o_tx_busy(o_tx_busy), .o_interrupt(o_interrupt));
  always #5 CLK_I = ~CLK_I;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  always @(negedge CLK_I)
    if (ACK_O && rd_req) begin
      rd_exp_t e;
      if (rd_q.size() == 0) chk("rd_q_size", 32'(rd_q.size()), 32'd1);
      else begin
        e = rd_q.pop_front();
        chk(e.nm, DAT_O, e.v);
      end
    end
  always @(frame_ev) begin
    fr_exp_t f;
    if (fr_q.size() == 0) chk("fr_q_size", 32'(fr_q.size()), 32'd1);
    else begin
      f = fr_q.pop_front();
      chk(f.nm, 32'(dev_bits), 32'(f.v));
    end
  end
  always @(negedge CLK_I)
    if (k_clk_oe) begin
      inh_run++;
      if (k_data_oe) inh_dat++;
    end else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_dlen = inh_dat;
      inh_run = 0;
      inh_dat = 0;
    end
  task automatic wb(input bit we, input logic [3:0] adr, input logic [31:0] dat);
    bit got = 1'b0;
    @(negedge CLK_I);
    STB_I = 1'b1;
    WE_I = we;
    ADR_I = 32'(adr);
    DAT_I = dat;
    rd_req = !we;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge CLK_I);
      #1 got = ACK_O;
    end
    chk("wb_ack", 32'(got), 32'd1);
    @(posedge CLK_I);
    #1;
    STB_I = 1'b0;
    WE_I = 1'b0;
    rd_req = 1'b0;
  endtask
  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    wb(1'b1, adr, dat);
  endtask
  task automatic rd(input logic [3:0] adr, input string nm, input logic [31:0] v);
    rd_q.push_back('{nm, v});
    wb(1'b0, adr, 32'd0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 2000 && o_tx_busy; i++) @(negedge CLK_I);
    chk("busy_clear", 32'(o_tx_busy), 32'd0);
  endtask
  // Device: waits for the request (clock released, data low), samples data mid-high phase, then drives a falling edge.
  task automatic dev_frame(input int edges, input bit ack);
    logic [10:0] b = '0;
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK_I);
      seen = k_clk_i && !k_data_i;
    end
    chk("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    repeat (10) @(negedge CLK_I);
    for (int i = 0; i < edges; i++) begin
      repeat (5) @(negedge CLK_I);
      b[i] = k_data_i;
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (5) @(negedge CLK_I);
      dev_clk = 1'b0;
      repeat (10) @(negedge CLK_I);
      dev_clk = 1'b1;
    end
    repeat (5) @(negedge CLK_I);
    dev_data = 1'b1;
    if (edges == 11) begin
      dev_bits = b;
      ->frame_ev;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit ack, input logic [10:0] frame);
    wr(4'h0, 32'(b));
    fr_q.push_back('{"frame", frame});
    dev_frame(11, ack);
    wait_idle();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge CLK_I);
    chk("rst_dat_o", DAT_O, 32'd0);
    chk("rst_ack", 32'(ACK_O), 32'd0);
    chk("rst_clk_oe", 32'(k_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(k_data_oe), 32'd0);
    chk("rst_busy", 32'(o_tx_busy), 32'd0);
    chk("rst_irq", 32'(o_interrupt), 32'd0);
    RST_I = 1'b0;
    rd(4'h4, "status_rst", 32'h00);
    rd(4'h0, "txdata_rst", 32'h00);
    send(8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    chk("inhibit_len", 32'(inh_len), 32'd20);
    chk("inhibit_data_len", 32'(inh_dlen), 32'd1);
    rd(4'h4, "status_ed", 32'h02);
    rd(4'h0, "txdata_ed", 32'hED);
    send(8'h01, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0});
    rd(4'h4, "status_nack", 32'h06);
    wr(4'h0, 32'hFF);
    repeat (300) @(negedge CLK_I);
    chk("t3_busy_mid", 32'(o_tx_busy), 32'd1);
    chk("t3_data_oe_mid", 32'(k_data_oe), 32'd1);
    chk("t3_clk_oe_mid", 32'(k_clk_oe), 32'd0);
    wait_idle();
    chk("t3_clk_oe", 32'(k_clk_oe), 32'd0);
    chk("t3_data_oe", 32'(k_data_oe), 32'd0);
    rd(4'h4, "status_timeout", 32'h0A);
    wr(4'h0, 32'h55);
    wr(4'h0, 32'hAA);
    fr_q.push_back('{"frame_ovr", {1'b1, 1'b1, 8'h55, 1'b0}});
    dev_frame(11, 1'b1);
    wait_idle();
    rd(4'h0, "txdata_ovr", 32'h55);
    rd(4'h4, "status_ovr", 32'h12);
    wr(4'h4, 32'h10);
    rd(4'h4, "status_ovr_w1c", 32'h02);
    wr(4'h0, 32'h00);
    dev_frame(4, 1'b0);
    chk("t5_data_oe_bit3", 32'(k_data_oe), 32'd1);
    chk("t5_busy_pre", 32'(o_tx_busy), 32'd1);
    #2 RST_I = 1'b1;
    #1;
    chk("t5_clk_oe_rst", 32'(k_clk_oe), 32'd0);
    chk("t5_data_oe_rst", 32'(k_data_oe), 32'd0);
    chk("t5_busy_rst", 32'(o_tx_busy), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    rd(4'h4, "status_t5_rst", 32'h00);
    send(8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    rd(4'h4, "status_t5_done", 32'h02);
`ifdef PS2_TX_IRQ_EN
    wr(4'h4, 32'h02);
    wr(4'h8, 32'h01);
    rd(4'h8, "ctrl", 32'h01);
    chk("irq_before", 32'(o_interrupt), 32'd0);
    send(8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});
    repeat (2) @(negedge CLK_I);
    chk("irq_done", 32'(o_interrupt), 32'd1);
    rd(4'h4, "status_f4", 32'h02);
    wr(4'h4, 32'h02);
    repeat (2) @(negedge CLK_I);
    chk("irq_cleared", 32'(o_interrupt), 32'd0);
`else
    rd(4'h8, "ctrl_absent", 32'h00);
    wr(4'h8, 32'h01);
    send(8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});
    repeat (2) @(negedge CLK_I);
    chk("irq_tied_low", 32'(o_interrupt), 32'd0);
    rd(4'h8, "ctrl_still_0", 32'h00);
    rd(4'h4, "status_f4", 32'h02);
`endif
    repeat (5) @(negedge CLK_I);
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);
    chk("fr_q_left", 32'(fr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
